// File: rtl/delay_fifo_seq_pkg.sv
// Shared types and helpers for the delay-buffer transfer sequencer.
package delay_fifo_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        FLUSH   = 3'd2,
        PURGE   = 3'd3,
        DONE    = 3'd4,
        ABORTED = 3'd5
    } state_t;

    // Shift counter spans 0..2*depth inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return unsigned'($clog2(2 * depth + 1));
    endfunction

endpackage

// File: rtl/delay_fifo_seq.sv
// Sequences one fill/flush transfer through an external shift-register delay
// buffer, with abort that zero-purges the buffer before returning to IDLE.
module delay_fifo_seq
    import delay_fifo_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned BITS  = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [BITS-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            fifo_en,
    output logic [BITS-1:0] fifo_d,
    input  logic [BITS-1:0] fifo_q,
    output logic [BITS-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy,
    output logic            done,
    output logic            aborted
);

    localparam int unsigned    SW     = cnt_w(DEPTH);
    localparam logic [SW-1:0] S_PRE  = SW'(DEPTH - 1);
    localparam logic [SW-1:0] S_FULL = SW'(DEPTH);
    localparam logic [SW-1:0] S_LAST = SW'(2 * DEPTH - 1);
    localparam logic [SW-1:0] P_LAST = SW'(DEPTH - 1);

    state_t        state;
    logic [SW-1:0] s_cnt;
    logic [SW-1:0] p_cnt;
    logic          shift;

    // Handshake and buffer drive decoded from state; abort suppresses any shift.
    always_comb begin
        out_valid = (state == FLUSH) || (state == FILL && s_cnt >= S_FULL);
        in_ready  = 1'b0;
        fifo_en   = 1'b0;
        fifo_d    = '0;
        shift     = 1'b0;
        case (state)
            FILL: begin
                in_ready = !abort && (!out_valid || out_ready);
                shift    = in_valid && in_ready;
                fifo_en  = shift;
                fifo_d   = in_data;
            end
            FLUSH: begin
                shift   = out_ready && !abort;
                fifo_en = shift;
            end
            PURGE: begin
                fifo_en = 1'b1;
            end
            default: ;
        endcase
    end

    assign out_data = fifo_q;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign aborted  = (state == ABORTED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            s_cnt <= '0;
            p_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state <= FILL;
                end
                FILL: begin
                    if (abort) begin
                        state <= PURGE;
                        p_cnt <= '0;
                    end else if (shift) begin
                        s_cnt <= s_cnt + SW'(1);
                        if (s_cnt == S_PRE) state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (abort) begin
                        state <= PURGE;
                        p_cnt <= '0;
                    end else if (shift) begin
                        s_cnt <= s_cnt + SW'(1);
                        if (s_cnt == S_LAST) state <= DONE;
                    end
                end
                PURGE: begin
                    p_cnt <= p_cnt + SW'(1);
                    if (p_cnt == P_LAST) state <= ABORTED;
                end
                DONE: begin
                    s_cnt <= '0;
                    state <= IDLE;
                end
                ABORTED: begin
                    s_cnt <= '0;
                    p_cnt <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_delay_fifo_seq.sv
// Directed bench for delay_fifo_seq with a behavioural shift-register buffer.
module tb_delay_fifo_seq;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned BITS  = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [BITS-1:0] in_data = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            fifo_en;
    logic [BITS-1:0] fifo_d;
    logic [BITS-1:0] fifo_q;
    logic [BITS-1:0] out_data;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            busy;
    logic            done;
    logic            aborted;
    logic            buf_rst_n;

    int checks   = 0;
    int failures = 0;

    logic [BITS-1:0] exp_beats [4];
    logic [BITS-1:0] fb [DEPTH];

    always #5 clk = ~clk;

    delay_fifo_seq #(.DEPTH(DEPTH), .BITS(BITS)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .fifo_en(fifo_en), .fifo_d(fifo_d), .fifo_q(fifo_q),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .aborted(aborted)
    );

    // Delay buffer as the wrapper would build it, reset by ~rst.
    assign buf_rst_n = ~rst;
    always_ff @(posedge clk or negedge buf_rst_n) begin
        if (!buf_rst_n) begin
            for (int i = 0; i < DEPTH; i++) fb[i] <= '0;
        end else if (fifo_en) begin
            fb[0] <= fifo_d;
            for (int i = 1; i < DEPTH; i++) fb[i] <= fb[i-1];
        end
    end
    assign fifo_q = fb[DEPTH-1];

    function automatic logic [4*BITS-1:0] buf_bits();
        return {fb[0], fb[1], fb[2], fb[3]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if ({busy, in_ready, fifo_en, out_valid, done, aborted} !== 6'b0 || buf_bits() !== '0) begin
            failures++;
            $display("FAIL reset_idle got busy/ir/en/ov/done/ab=%b buf=%h exp 000000 buf=0",
                     {busy, in_ready, fifo_en, out_valid, done, aborted}, buf_bits());
        end
        rst = 1'b0;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = exp_beats[i];
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, in_ready, fifo_en, out_valid, done, aborted} !== 6'b0 || buf_bits() !== '0) begin
            failures++;
            $display("FAIL reset_mid_fill got busy/ir/en/ov/done/ab=%b buf=%h exp 000000 buf=0",
                     {busy, in_ready, fifo_en, out_valid, done, aborted}, buf_bits());
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    // One full transfer; bubble toggles in_valid, stall holds out_ready low at FLUSH entry.
    task automatic run_transfer(input string tag, input bit bubble, input int stall);
        int n_in = 0, n_out = 0, stall_left = stall;
        int ready_cyc = 0, ovalid_cyc = 0, last_cyc = -10, cyc = 0;
        bit fill;
        start = 1'b1; tick(); start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL %s_busy_after_start got=%b exp=1", tag, busy);
        end
        while (!done && cyc < 40) begin
            fill      = busy && !out_valid;
            in_valid  = (n_in < 4) && (!bubble || cyc[0] == 1'b0);
            in_data   = in_valid ? exp_beats[n_in[1:0]] : 8'h00;
            out_ready = !(out_valid && stall_left > 0);
            #1;
            if (in_ready) ready_cyc++;
            if (fill) begin
                checks++;
                if (in_ready !== 1'b1 || fifo_en !== in_valid || fifo_d !== in_data) begin
                    failures++;
                    $display("FAIL %s_fill cyc=%0d got ir=%b en=%b d=%h exp ir=1 en=%b d=%h",
                             tag, cyc, in_ready, fifo_en, fifo_d, in_valid, in_data);
                end
            end
            if (out_valid) begin
                ovalid_cyc++;
                checks++;
                if (out_data !== exp_beats[n_out[1:0]] || fifo_en !== out_ready || in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_flush cyc=%0d got data=%h en=%b ir=%b exp data=%h en=%b ir=0",
                             tag, cyc, out_data, fifo_en, in_ready, exp_beats[n_out[1:0]], out_ready);
                end
                if (out_ready) begin
                    n_out++; last_cyc = cyc;
                end else begin
                    stall_left--;
                end
            end
            if (in_valid && in_ready) n_in++;
            tick();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        checks++;
        if (done !== 1'b1 || n_in != 4 || n_out != 4 || cyc != last_cyc + 1) begin
            failures++;
            $display("FAIL %s_done got done=%b in=%0d out=%0d cyc=%0d exp done=1 in=4 out=4 cyc=%0d",
                     tag, done, n_in, n_out, cyc, last_cyc + 1);
        end
        checks++;
        if (ovalid_cyc != 4 + stall || ready_cyc != (bubble ? 7 : 4)) begin
            failures++;
            $display("FAIL %s_counts got ovalid=%0d ready=%0d exp ovalid=%0d ready=%0d",
                     tag, ovalid_cyc, ready_cyc, 4 + stall, bubble ? 7 : 4);
        end
        checks++;
        if (out_valid !== 1'b0 || fifo_en !== 1'b0 || buf_bits() !== '0) begin
            failures++;
            $display("FAIL %s_drained got ov=%b en=%b buf=%h exp ov=0 en=0 buf=0",
                     tag, out_valid, fifo_en, buf_bits());
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle got done=%b busy=%b exp 0 0", tag, done, busy);
        end
    endtask

    task automatic test_back_to_back();
        run_transfer("b2b", 1'b0, 0);
    endtask

    task automatic test_host_bubbles();
        run_transfer("bubble", 1'b1, 0);
    endtask

    task automatic test_consumer_stall();
        run_transfer("stall", 1'b0, 3);
    endtask

    task automatic test_abort_flush();
        int n = 0;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 8 && !out_valid; c++) begin
            in_valid = 1'b1; in_data = exp_beats[n[1:0]];
            #1;
            if (in_ready) n++;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h11 || fifo_en !== 1'b1) begin
            failures++;
            $display("FAIL abort_first_beat got ov=%b data=%h en=%b exp ov=1 data=11 en=1",
                     out_valid, out_data, fifo_en);
        end
        tick();
        abort = 1'b1;
        #1;
        checks++;
        if (fifo_en !== 1'b0 || out_data !== 8'h22) begin
            failures++;
            $display("FAIL abort_no_shift got en=%b data=%h exp en=0 data=22", fifo_en, out_data);
        end
        tick();
        abort = 1'b0; out_ready = 1'b0;
        n = 0;
        for (int c = 0; c < 10 && !aborted; c++) begin
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0 || fifo_en !== 1'b1 || fifo_d !== 8'h00) begin
                failures++;
                $display("FAIL abort_purge cyc=%0d got ov=%b ir=%b en=%b d=%h exp ov=0 ir=0 en=1 d=00",
                         c, out_valid, in_ready, fifo_en, fifo_d);
            end
            n++;
            tick();
        end
        checks++;
        if (aborted !== 1'b1 || n != 4 || busy !== 1'b1 || fifo_en !== 1'b0 || buf_bits() !== '0) begin
            failures++;
            $display("FAIL abort_pulse got ab=%b purge=%0d busy=%b en=%b buf=%h exp ab=1 purge=4 busy=1 en=0 buf=0",
                     aborted, n, busy, fifo_en, buf_bits());
        end
        tick();
        checks++;
        if (aborted !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle got ab=%b busy=%b exp 0 0", aborted, busy);
        end
    endtask

    task automatic test_ignored_pulses();
        logic [4*BITS-1:0] snap;
        abort = 1'b1;
        #1;
        checks++;
        if (fifo_en !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL idle_abort_drive got en=%b ir=%b exp 0 0", fifo_en, in_ready);
        end
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || aborted !== 1'b0) begin
            failures++;
            $display("FAIL idle_abort_state got busy=%b ab=%b exp 0 0", busy, aborted);
        end
        start = 1'b1; tick();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = exp_beats[i];
            tick();
        end
        start = 1'b0;
        in_data = 8'h99;
        abort = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || fifo_en !== 1'b0) begin
            failures++;
            $display("FAIL abort_vs_beat got busy=%b ir=%b en=%b exp busy=1 ir=0 en=0", busy, in_ready, fifo_en);
        end
        snap = buf_bits();
        tick();
        abort = 1'b0; in_valid = 1'b0;
        checks++;
        if (buf_bits() !== snap || snap !== {8'h22, 8'h11, 16'h0} || out_valid !== 1'b0 || fifo_en !== 1'b1) begin
            failures++;
            $display("FAIL abort_purge_entry got buf=%h ov=%b en=%b exp buf=22110000 ov=0 en=1",
                     buf_bits(), out_valid, fifo_en);
        end
        for (int c = 0; c < 10 && !aborted; c++) tick();
        checks++;
        if (aborted !== 1'b1 || buf_bits() !== '0) begin
            failures++;
            $display("FAIL abort_fill_end got ab=%b buf=%h exp ab=1 buf=0", aborted, buf_bits());
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_fill_idle got busy=%b exp 0", busy);
        end
    endtask

    initial begin
        exp_beats[0] = 8'h11;
        exp_beats[1] = 8'h22;
        exp_beats[2] = 8'h33;
        exp_beats[3] = 8'h44;
        test_reset();
        test_back_to_back();
        test_host_bubbles();
        test_consumer_stall();
        test_abort_flush();
        test_ignored_pulses();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
